// File: rtl/beta_sram_ctrl.sv
// beta_sram_ctrl
// Sequences the beta-metric SRAM of the MAP decoder. A block runs the
// backward recursion (steps N_STEPS-1 down to 0), writing one 8-word
// group per step, then the forward read-out (steps 0 up to N_STEPS-1)
// that feeds the LLR unit. Word group for step k lives at address 8*k;
// the boundary group for step N_STEPS is loaded by the sram_init pulse.
//
// Ports
//   clk, rst         clock, asynchronous active-low reset
//   start, abort     block start (IDLE only), synchronous abort
//   busy, done       activity flag, end-of-block pulse
//   sram_init        SRAM reset pulse (loads boundary metrics)
//   sram_we          1 = write, 0 = read
//   sram_addr        SRAM base address {k,3'b000} or {k+1,3'b000}
//   beta_req/valid   handshake with the beta compute unit
//   llr_req/ready    handshake with the LLR unit
//   step             current trellis step k
//
// state | meaning
// IDLE  | waiting for start, all outputs at reset values
// INIT  | pulse sram_init, k = N_STEPS-1
// BRD   | read beta(k+1) at 8*(k+1)
// BCALC | beta unit computes beta(k), waits for beta_valid
// BWR   | single write of beta(k) at 8*k
// FRD   | read beta(k) at 8*k
// FOUT  | LLR unit consumes beta(k), waits for llr_ready
// DONE  | one-cycle done pulse
module beta_sram_ctrl #(
  parameter int N_STEPS = 8,
  parameter int ADDR_W  = 8,
  parameter int STEP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              sram_init,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              beta_req,
  input  logic              beta_valid,
  output logic              llr_req,
  input  logic              llr_ready,
  output logic [STEP_W-1:0] step
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_BRD, S_BCALC, S_BWR, S_FRD, S_FOUT, S_DONE
  } state_t;

  localparam logic [STEP_W-1:0] K_LAST = STEP_W'(N_STEPS - 1);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   k_q, k_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                init_q, init_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                breq_q, breq_d;
  logic                lreq_q, lreq_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [STEP_W:0]     k_inc;

  // State register; outputs are registered from the next-state decode so
  // they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      breq_q  <= 1'b0;
      lreq_q  <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      init_q  <= init_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      breq_q  <= breq_d;
      lreq_q  <= lreq_d;
      step_q  <= step_d;
    end
  end

  // Next state and step index
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          k_d     = K_LAST;
        end
      end
      S_INIT:  state_d = S_BRD;
      S_BRD:   state_d = S_BCALC;
      S_BCALC: if (beta_valid) state_d = S_BWR;
      S_BWR: begin
        if (k_q == '0) begin
          state_d = S_FRD;
        end else begin
          state_d = S_BRD;
          k_d     = k_q - STEP_W'(1);
        end
      end
      S_FRD:   state_d = S_FOUT;
      S_FOUT: begin
        if (llr_ready) begin
          if (k_q == K_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FRD;
            k_d     = k_q + STEP_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        k_d     = '0;
      end
    endcase
    // Abort wins over every transition; IDLE restores k to its reset value
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      k_d     = '0;
    end
  end

  // Output decode from the upcoming state
  always_comb begin
    k_inc  = {1'b0, k_d} + (STEP_W+1)'(1);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    init_d = (state_d == S_INIT);
    we_d   = (state_d == S_BWR);
    breq_d = (state_d == S_BCALC);
    lreq_d = (state_d == S_FOUT);
    step_d = k_d;
    addr_d = '0;
    case (state_d)
      S_BRD, S_BCALC:      addr_d = ADDR_W'({k_inc, 3'b000});
      S_BWR, S_FRD, S_FOUT: addr_d = ADDR_W'({k_d, 3'b000});
      default:             addr_d = '0;
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sram_init = init_q;
  assign sram_we   = we_q;
  assign sram_addr = addr_q;
  assign beta_req  = breq_q;
  assign llr_req   = lreq_q;
  assign step      = step_q;

endmodule
